mul_share_arb: RTL and testbench
================================

# mul_share_arb

Two-requester controller that time-shares one combinational `myhlr` hybrid radix-4/approx radix-8 16×16 multiplier. It arbitrates round-robin, registers the winning operands, captures the product, and returns it on the winner's response channel with a valid/ready handshake. It sits between operand producers and the single multiplier instance, so the multiplier's combinational path is bounded by registers on both sides.

## Interface
- `W`, 16, operand width; the result is 2·W bits.
- `CNT_W`, 32, width of the completed-operation counter.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1, `req0_ready` out 1, `req0_a` in W, `req0_b` in W: operand channel 0.
- `req1_valid` in 1, `req1_ready` out 1, `req1_a` in W, `req1_b` in W: operand channel 1.
- `rsp0_valid` out 1, `rsp0_ready` in 1, `rsp0_result` out 2W: response channel 0.
- `rsp1_valid` out 1, `rsp1_ready` in 1, `rsp1_result` out 2W: response channel 1.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out CNT_W: number of completed response handshakes; saturates at all-ones.

## Operation
- FSM states:
  - IDLE: the block can accept a request.
  - MUL: operand registers drive `myhlr`; the product is captured at the end of this cycle.
  - RESP: the response is presented; the block waits for `rspN_ready`.
- IDLE transitions:
  - If no request is valid, stay in IDLE.
  - If only one request is valid, grant it.
  - If both are valid, grant the requester not served last; `last_grant` resets to 1, so requester 0 wins the first tie.
- `reqN_ready` is 1 only when the state is IDLE and requester N is the current grant. It is combinational from the valids and `last_grant`, and is never high for both requesters.
- On acceptance (`reqN_valid & reqN_ready`):
  - latch `a`, `b` and the owner index;
  - update `last_grant` to N;
  - go to MUL.
- MUL: capture the multiplier output into the result register, then always go to RESP. The result is the `myhlr` output unmodified; the block applies no correction for approximation.
- RESP:
  - Only the owner's `rspN_valid` is 1. `rspN_result` holds the registered product and stays stable while valid.
  - On `rspN_valid & rspN_ready`: go to IDLE and increment `op_count`, which holds at 2^CNT_W−1.
- Inputs changing while the block is not in IDLE have no effect; non-owner requesters see `ready=0`.
- The non-owner's response outputs: `rsp_valid=0` and `rsp_result` = 0.

## Timing
- Reset values:
  - state = IDLE, `last_grant`=1;
  - operand and result registers = 0, `op_count`=0;
  - all `rsp*_valid`=0, `busy`=0;
  - `req*_ready` follow the IDLE rule from the first cycle after reset.
- Latency: accept in cycle N → MUL in N+1 → `rsp_valid` high in N+2.
- If `rsp_ready` is already high in N+2, the handshake completes that cycle and the state is IDLE in N+3.
- Maximum throughput: one operation per 3 cycles. There is no accept in the same cycle as a response handshake.
- Backpressure: RESP holds indefinitely; the result and valid stay constant.
- Reset in MUL or RESP:
  - the in-flight operation is dropped and no response is issued;
  - `op_count` clears;
  - the state is IDLE on the next cycle.
- Width rule: operands are unsigned W bits and the product is 2W bits. Extremes (0, 0xFFFF) pass through with no truncation in the controller.

## Structure
- Package `mul_share_pkg` holds:
  - the `W` and `CNT_W` defaults;
  - the state enum (IDLE, MUL, RESP);
  - the requester-index type (1 bit).
- One sub-module: the existing `myhlr` (ports `A`, `B`, `result`), instantiated once and driven only from the operand registers.
- Round-robin arbitration, the FSM and the counter are inline; no separate arbiter module.

## Test plan
- **Reset:** hold `rst` for 2 cycles with both valids high → during reset, no ready or `rsp_valid` and `op_count`=0; after release, `req0_ready`=1 (tie goes to requester 0).
- **Single request, requester 0:** `a=3`, `b=5`, `rsp0_ready`=1 → `rsp0_valid` in cycle N+2 with the result equal to a standalone `myhlr`(3,5); IDLE in N+3; `op_count`=1.
- **Contention:** both valid continuously with distinct operands, responses always ready → grants alternate 0,1,0,1 across 8 operations, each result matches its own operands, `op_count`=8.
- **Backpressure:** `rsp1_ready`=0 for 10 cycles → `rsp1_valid` and `rsp1_result` are stable, `req0_ready`=0 throughout, and requester 0 is served only after the handshake.
- **Extremes:** `a=0,b=0xFFFF` → 0; `a=b=0xFFFF` → equals the standalone `myhlr` output bit-for-bit (exact reference 0xFFFE0001 logged for error reporting).
- **Mid-operation reset:** assert `rst` in MUL, then separately in RESP → no response appears, `op_count`=0, and a new request is accepted normally afterwards.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the two-requester multiplier-sharing controller.
package mul_share_pkg;

  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/myhlr.sv
// Hybrid multiplier: the low six bits of B are recoded as two radix-8 Booth
// digits whose hard multiple (3A) has its low APX bits cleared; the remaining
// bits of B are recoded as exact radix-4 Booth digits. Operands are unsigned.
module myhlr #(
  parameter int W = 16
) (
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] result
);

  localparam int PW  = 2 * W;
  localparam int APX = 2;
  localparam int NR4 = W / 2 - 2;

  logic [W+2:0]          bx;
  logic signed [PW-1:0]  a1;
  logic signed [PW-1:0]  a3x;
  logic signed [PW-1:0]  a3;
  logic signed [PW-1:0]  acc;

  function automatic logic signed [PW-1:0] r8_pp(input logic [3:0] g,
                                                 input logic signed [PW-1:0] m1,
                                                 input logic signed [PW-1:0] m3);
    logic signed [PW-1:0] pp;
    pp = '0;
    case (g)
      4'b0001, 4'b0010: pp = m1;
      4'b0011, 4'b0100: pp = m1 <<< 1;
      4'b0101, 4'b0110: pp = m3;
      4'b0111:          pp = m1 <<< 2;
      4'b1000:          pp = -(m1 <<< 2);
      4'b1001, 4'b1010: pp = -m3;
      4'b1011, 4'b1100: pp = -(m1 <<< 1);
      4'b1101, 4'b1110: pp = -m1;
      default:          pp = '0;
    endcase
    return pp;
  endfunction

  function automatic logic signed [PW-1:0] r4_pp(input logic [2:0] g,
                                                 input logic signed [PW-1:0] m1);
    logic signed [PW-1:0] pp;
    pp = '0;
    case (g)
      3'b001, 3'b010: pp = m1;
      3'b011:         pp = m1 <<< 1;
      3'b100:         pp = -(m1 <<< 1);
      3'b101, 3'b110: pp = -m1;
      default:        pp = '0;
    endcase
    return pp;
  endfunction

  assign bx  = {2'b00, B, 1'b0};
  assign a1  = {{W{1'b0}}, A};
  assign a3x = a1 + (a1 <<< 1);
  assign a3  = {a3x[PW-1:APX], {APX{1'b0}}};

  // Sum the radix-8 (approximate) and radix-4 (exact) partial products
  always_comb begin
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      acc = acc + (r8_pp(bx[3*i+3 -: 4], a1, a3) <<< (3*i));
    end
    for (int j = 0; j < NR4; j++) begin
      acc = acc + (r4_pp(bx[2*j+8 -: 3], a1) <<< (2*j+6));
    end
  end

  assign result = acc;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin controller that time-shares one myhlr multiplier between two
// valid/ready operand channels and returns each product on the owner's
// response channel.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [2*W-1:0]   rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [2*W-1:0]   rsp1_result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t         state;
  req_idx_t       last_grant;
  req_idx_t       owner;
  req_idx_t       gnt;
  logic           idle_ok;
  logic           acc0;
  logic           acc1;
  logic           rsp_hs;
  logic [W-1:0]   a_p0;
  logic [W-1:0]   b_p0;
  logic [2*W-1:0] mul_out;
  logic [2*W-1:0] prod_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt = ~last_grant;
    end else if (req1_valid) begin
      gnt = 1'b1;
    end
  end

  assign idle_ok    = ~rst && (state == S_IDLE);
  assign req0_ready = idle_ok & req0_valid & ~gnt;
  assign req1_ready = idle_ok & req1_valid & gnt;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  assign rsp0_result = rsp0_valid ? prod_p1 : '0;
  assign rsp1_result = rsp1_valid ? prod_p1 : '0;

  myhlr #(.W(W)) u_mul (
    .A      (a_p0),
    .B      (b_p0),
    .result (mul_out)
  );

  // Controller FSM: accept -> multiply -> hold response until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_p0       <= '0;
      b_p0       <= '0;
      prod_p1    <= '0;
      op_count   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // operand stage p0: latch the winner's operands
          if (acc0 || acc1) begin
            owner      <= acc1;
            last_grant <= acc1;
            a_p0       <= acc1 ? req1_a : req0_a;
            b_p0       <= acc1 ? req1_b : req0_b;
            busy       <= 1'b1;
            state      <= S_MUL;
          end
        end
        S_MUL: begin
          // product stage p1: capture the multiplier output
          prod_p1    <= mul_out;
          rsp0_valid <= (owner == 1'b0);
          rsp1_valid <= (owner == 1'b1);
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            op_count   <= sat_inc(op_count);
            state      <= S_IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed-plus-random bench for mul_share_arb with an arithmetic reference
// model of the hybrid multiplier and of the round-robin/counter behaviour.
module tb_mul_share_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        busy;
  logic [31:0] op_count;

  int          tests = 0;
  int          fails = 0;
  int          exp_cnt;
  bit          exp_last;
  bit          exp_g;
  logic [15:0] oa [2];
  logic [15:0] ob [2];
  logic [31:0] held;

  mul_share_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Exact product, then for every low radix-8 digit equal to +/-3 remove the
  // low two bits of 3A that the approximate multiple drops.
  function automatic logic [31:0] mdl(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint lost;
    logic [16:0] bx;
    int d;
    bx   = {b, 1'b0};
    p    = longint'(a) * longint'(b);
    lost = (3 * longint'(a)) & 3;
    for (int i = 0; i < 2; i++) begin
      d = -4 * int'(bx[3*i+3]) + 2 * int'(bx[3*i+2]) + int'(bx[3*i+1]) + int'(bx[3*i]);
      if (d == 3)  p = p - (lost << (3*i));
      if (d == -3) p = p + (lost << (3*i));
    end
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    req0_a = oa[0]; req0_b = ob[0];
    req1_a = oa[1]; req1_b = ob[1];
  endtask

  task automatic single_op(input bit ch, input logic [15:0] a, input logic [15:0] b,
                           input string tag);
    oa[ch] = a; ob[ch] = b;
    drive_ops();
    req0_valid = (ch == 1'b0);
    req1_valid = (ch == 1'b1);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, ch ? req1_ready : req0_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    step();
    chk({tag, "_vld"}, ch ? rsp1_valid : rsp0_valid, 1);
    chk({tag, "_ovld"}, ch ? rsp0_valid : rsp1_valid, 0);
    chk({tag, "_res"}, ch ? rsp1_result : rsp0_result, mdl(a, b));
    step();
    exp_cnt++;
    exp_last = ch;
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_cnt"}, op_count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    oa[0] = 16'($urandom); ob[0] = 16'($urandom);
    oa[1] = 16'($urandom); ob[1] = 16'($urandom);
    drive_ops();

    // reset held two cycles with both requesters valid
    step();
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rdy1", req1_ready, 0);
    chk("rst_rvld0", rsp0_valid, 0);
    chk("rst_rvld1", rsp1_valid, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_busy", busy, 0);
    step();
    chk("rst2_rdy0", req0_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy0", req0_ready, 1);
    chk("post_rst_rdy1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_cnt = 0; exp_last = 1'b1;
    step();
    chk("idle_cnt", op_count, 0);

    // single request on channel 0
    single_op(1'b0, 16'd3, 16'd5, "single");

    // contention: both valid every cycle, responses always ready
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      oa[k] = 16'($urandom); ob[k] = 16'($urandom);
    end
    drive_ops();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_g = ~exp_last;
      chk("cont_rdy0", req0_ready, !exp_g);
      chk("cont_rdy1", req1_ready, exp_g);
      step();
      step();
      chk("cont_vld", exp_g ? rsp1_valid : rsp0_valid, 1);
      chk("cont_ovld", exp_g ? rsp0_valid : rsp1_valid, 0);
      chk("cont_res", exp_g ? rsp1_result : rsp0_result, mdl(oa[exp_g], ob[exp_g]));
      oa[exp_g] = 16'($urandom); ob[exp_g] = 16'($urandom);
      drive_ops();
      step();
      exp_cnt++;
      exp_last = exp_g;
    end
    chk("cont_cnt", op_count, exp_cnt);

    // backpressure on channel 1 while channel 0 keeps requesting
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    oa[0] = 16'($urandom); ob[0] = 16'($urandom);
    oa[1] = 16'($urandom); ob[1] = 16'($urandom);
    drive_ops();
    #1;
    chk("bp_rdy1", req1_ready, (exp_last == 1'b0) ? 1 : 0);
    step();
    step();
    held = mdl(oa[1], ob[1]);
    for (int k = 0; k < 10; k++) begin
      chk("bp_vld1", rsp1_valid, 1);
      chk("bp_res1", rsp1_result, held);
      chk("bp_rdy0", req0_ready, 0);
      chk("bp_vld0", rsp0_valid, 0);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      step();
    end
    rsp1_ready = 1'b1;
    step();
    exp_cnt++; exp_last = 1'b1;
    chk("bp_after_rdy0", req0_ready, 1);
    chk("bp_after_rdy1", req1_ready, 0);
    step();
    step();
    chk("bp_vld0_served", rsp0_valid, 1);
    chk("bp_res0", rsp0_result, mdl(oa[0], ob[0]));
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    exp_cnt++; exp_last = 1'b0;
    chk("bp_cnt", op_count, exp_cnt);

    // operand extremes
    single_op(1'b0, 16'h0000, 16'hFFFF, "ext_zero");
    chk("ext_zero_lit", rsp0_result, 0);
    single_op(1'b1, 16'hFFFF, 16'hFFFF, "ext_max");
    $display("[TB] exact 0xFFFF*0xFFFF reference is 0xFFFE0001, model gives 0x%08h",
             mdl(16'hFFFF, 16'hFFFF));

    // random single operations on random channels
    for (int k = 0; k < 6; k++) begin
      single_op(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), "rand");
    end

    // reset while in MUL
    oa[0] = 16'($urandom); ob[0] = 16'($urandom);
    drive_ops();
    req0_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    step();
    req0_valid = 1'b0;
    chk("mr_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0; exp_last = 1'b1;
    chk("mr_busy", busy, 0);
    chk("mr_cnt", op_count, 0);
    for (int k = 0; k < 3; k++) begin
      chk("mr_novld", {rsp0_valid, rsp1_valid}, 0);
      step();
    end

    // reset while in RESP
    req0_valid = 1'b1; rsp0_ready = 1'b0;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    chk("rr_vld_pre", rsp0_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_vld", rsp0_valid, 0);
    chk("rr_busy", busy, 0);
    chk("rr_cnt", op_count, 0);
    rsp0_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rr_novld", {rsp0_valid, rsp1_valid}, 0);
      step();
    end
    single_op(1'b1, 16'($urandom), 16'($urandom), "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
